// File: rtl/battleship_turn_scorer.sv
// Battleship turn scorer: accepts single-cell or 3x3 "Big" shots against a fixed
// fleet, remembers which ship cells have been hit, and reports per-shot results,
// sunk ships, remaining bombs/shots and game-over status.
module battleship_turn_scorer #(
  parameter int GRID_MAX  = 10,
  parameter int NUM_BIG   = 3,
  parameter int MAX_SHOTS = 30
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [3:0]                       X,
  input  logic [3:0]                       Y,
  input  logic                             Big,
  input  logic                             ScoreThis,
  output logic                             Ready,
  output logic                             Done,
  output logic                             Hit,
  output logic                             nearMiss,
  output logic                             Miss,
  output logic                             SomethingIsWrong,
  output logic [3:0]                       HitCount,
  output logic [6:0]                       numHits,
  output logic [4:0]                       BiggestShipHit,
  output logic [5:0]                       SunkMask,
  output logic [$clog2(NUM_BIG+1)-1:0]     BigLeft,
  output logic [$clog2(MAX_SHOTS+1)-1:0]   ShotsLeft,
  output logic                             GameOver,
  output logic                             Won
);

  localparam int BW = $clog2(NUM_BIG + 1);
  localparam int SW = $clog2(MAX_SHOTS + 1);
  localparam logic [4:0] GMAX5   = 5'(GRID_MAX);
  localparam logic [4:0] NO_SHIP = 5'd31;

  typedef enum logic [1:0] {S_READY, S_SCAN, S_REPORT, S_OVER} state_t;

  state_t state, state_nxt;

  // Ship cells are numbered 0..18: carrier 0-4, battleship 5-8, cruiser 9-11,
  // sub 12-14, patrol1 15-16, patrol2 17-18. NO_SHIP for water.
  function automatic logic [4:0] ship_idx(input logic [4:0] cx, input logic [4:0] cy);
    logic [4:0] r;
    r = NO_SHIP;
    if      (cy == 5'd3 && cx >= 5'd2 && cx <= 5'd6)  r = cx - 5'd2;
    else if (cy == 5'd2 && cx >= 5'd1 && cx <= 5'd4)  r = cx + 5'd4;
    else if (cy == 5'd1 && cx >= 5'd2 && cx <= 5'd4)  r = cx + 5'd7;
    else if (cx == 5'd2 && cy >= 5'd8 && cy <= 5'd10) r = cy + 5'd4;
    else if (cy == 5'd6 && cx >= 5'd7 && cx <= 5'd8)  r = cx + 5'd8;
    else if (cy == 5'd1 && cx >= 5'd9 && cx <= 5'd10) r = cx + 5'd8;
    return r;
  endfunction

  function automatic logic is_ship(input logic [4:0] cx, input logic [4:0] cy);
    return ship_idx(cx, cy) != NO_SHIP;
  endfunction

  // One-hot ship class, larger ships in higher bits so magnitude gives priority.
  function automatic logic [4:0] ship_class(input logic [4:0] idx);
    logic [4:0] r;
    if      (idx <= 5'd4)  r = 5'b10000;
    else if (idx <= 5'd8)  r = 5'b01000;
    else if (idx <= 5'd11) r = 5'b00100;
    else if (idx <= 5'd14) r = 5'b00010;
    else                   r = 5'b00001;
    return r;
  endfunction

  // Latched shot and scan/accumulator registers
  logic [3:0]  lx, ly;
  logic        lbig;
  logic [1:0]  di, dj;
  logic [3:0]  acc_cnt;
  logic [4:0]  acc_big;
  logic        acc_near;
  logic [18:0] hitmem;

  // Scan-cycle combinational view
  logic [4:0]  cx, cy, idx, cls;
  logic        cell_ok, on_ship, newhit, near_cell, last;
  logic [18:0] hitmem_nxt;
  logic [3:0]  cnt_nxt;
  logic [4:0]  big_nxt;
  logic        near_nxt;
  logic [5:0]  sunk_nxt;
  logic        req_ok;

  // Current scan cell, hit/near classification and next accumulator values
  always_comb begin
    cx = lbig ? ({1'b0, lx} + {3'b0, di} - 5'd1) : {1'b0, lx};
    cy = lbig ? ({1'b0, ly} + {3'b0, dj} - 5'd1) : {1'b0, ly};
    cell_ok   = (cx != 5'd0) && (cx <= GMAX5) && (cy != 5'd0) && (cy <= GMAX5);
    idx       = ship_idx(cx, cy);
    cls       = ship_class(idx);
    on_ship   = cell_ok && (idx != NO_SHIP);
    newhit    = on_ship && !hitmem[idx];
    near_cell = cell_ok && (idx == NO_SHIP) &&
                (is_ship(cx + 5'd1, cy) || is_ship(cx - 5'd1, cy) ||
                 is_ship(cx, cy + 5'd1) || is_ship(cx, cy - 5'd1));
    hitmem_nxt = hitmem;
    if (newhit) hitmem_nxt[idx] = 1'b1;
    cnt_nxt  = acc_cnt + {3'b0, newhit};
    big_nxt  = (newhit && (cls > acc_big)) ? cls : acc_big;
    near_nxt = acc_near | near_cell;
    last     = !lbig || (di == 2'd2 && dj == 2'd2);
    sunk_nxt = {&hitmem_nxt[4:0], &hitmem_nxt[8:5], &hitmem_nxt[11:9],
                &hitmem_nxt[14:12], &hitmem_nxt[16:15], &hitmem_nxt[18:17]};
    req_ok   = ({1'b0, X} != 5'd0) && ({1'b0, X} <= GMAX5) &&
               ({1'b0, Y} != 5'd0) && ({1'b0, Y} <= GMAX5) &&
               !(Big && (BigLeft == '0));
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_READY;
    else       state <= state_nxt;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nxt = state;
    Ready     = 1'b0;
    Done      = 1'b0;
    case (state)
      S_READY: begin
        Ready = 1'b1;
        if (ScoreThis) state_nxt = req_ok ? S_SCAN : S_REPORT;
      end
      S_SCAN:   if (last) state_nxt = S_REPORT;
      S_REPORT: begin
        Done      = 1'b1;
        state_nxt = GameOver ? S_OVER : S_READY;
      end
      default:  state_nxt = S_OVER;
    endcase
  end

  // Shot latch, scan accumulation, hit memory and result/counter registers.
  // Results are loaded on the edge entering REPORT so they are valid with Done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lx <= '0; ly <= '0; lbig <= 1'b0; di <= '0; dj <= '0;
      acc_cnt <= '0; acc_big <= '0; acc_near <= 1'b0; hitmem <= '0;
      Hit <= 1'b0; nearMiss <= 1'b0; Miss <= 1'b0; SomethingIsWrong <= 1'b0;
      HitCount <= '0; BiggestShipHit <= '0; SunkMask <= '0;
      BigLeft <= BW'(NUM_BIG); ShotsLeft <= SW'(MAX_SHOTS);
      GameOver <= 1'b0; Won <= 1'b0;
    end else begin
      case (state)
        S_READY: if (ScoreThis) begin
          lx <= X; ly <= Y; lbig <= Big;
          di <= '0; dj <= '0;
          acc_cnt <= '0; acc_big <= '0; acc_near <= 1'b0;
          if (!req_ok) begin
            SomethingIsWrong <= 1'b1;
            Hit <= 1'b0; nearMiss <= 1'b0; Miss <= 1'b0;
            HitCount <= '0; BiggestShipHit <= '0;
          end
        end
        S_SCAN: begin
          hitmem   <= hitmem_nxt;
          acc_cnt  <= cnt_nxt;
          acc_big  <= big_nxt;
          acc_near <= near_nxt;
          if (dj == 2'd2) begin
            dj <= '0;
            di <= di + 2'd1;
          end else begin
            dj <= dj + 2'd1;
          end
          if (last) begin
            SomethingIsWrong <= 1'b0;
            HitCount       <= cnt_nxt;
            Hit            <= (cnt_nxt != '0);
            nearMiss       <= (cnt_nxt == '0) && near_nxt;
            Miss           <= (cnt_nxt == '0) && !near_nxt;
            BiggestShipHit <= big_nxt;
            SunkMask       <= sunk_nxt;
            ShotsLeft      <= ShotsLeft - SW'(1);
            if (lbig) BigLeft <= BigLeft - BW'(1);
            Won      <= &sunk_nxt;
            GameOver <= (&sunk_nxt) || (ShotsLeft == SW'(1));
          end
        end
        default: ;
      endcase
    end
  end

  // Active-low seven-segment (gfedcba) of HitCount
  always_comb begin
    case (HitCount)
      4'd0:    numHits = 7'b100_0000;
      4'd1:    numHits = 7'b111_1001;
      4'd2:    numHits = 7'b010_0100;
      4'd3:    numHits = 7'b011_0000;
      4'd4:    numHits = 7'b001_1001;
      4'd5:    numHits = 7'b001_0010;
      4'd6:    numHits = 7'b000_0010;
      4'd7:    numHits = 7'b111_1000;
      4'd8:    numHits = 7'b000_0000;
      4'd9:    numHits = 7'b001_0000;
      default: numHits = 7'h7F;
    endcase
  end

endmodule

// File: tb/tb_battleship_turn_scorer.sv
// Self-checking bench for battleship_turn_scorer: directed scenarios plus random
// shots scored against a grid-level reference model.
module tb_battleship_turn_scorer;
  localparam int G  = 10;
  localparam int NB = 3;
  localparam int MS = 30;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] X, Y;
  logic       Big, ScoreThis, ScoreThis2;

  logic       Ready, Done, Hit, nearMiss, Miss, Wrong, GameOver, Won;
  logic [3:0] HitCount;
  logic [6:0] numHits;
  logic [4:0] Biggest;
  logic [5:0] Sunk;
  logic [1:0] BigLeft;
  logic [4:0] ShotsLeft;

  logic       Ready2, Done2, Hit2, Near2, Miss2, Wrong2, GameOver2, Won2;
  logic [3:0] HitCount2;
  logic [6:0] numHits2;
  logic [4:0] Biggest2;
  logic [5:0] Sunk2;
  logic [1:0] BigLeft2;
  logic [1:0] ShotsLeft2;

  battleship_turn_scorer #(.GRID_MAX(G), .NUM_BIG(NB), .MAX_SHOTS(MS)) dut (
    .clock(clock), .reset(reset), .X(X), .Y(Y), .Big(Big), .ScoreThis(ScoreThis),
    .Ready(Ready), .Done(Done), .Hit(Hit), .nearMiss(nearMiss), .Miss(Miss),
    .SomethingIsWrong(Wrong), .HitCount(HitCount), .numHits(numHits),
    .BiggestShipHit(Biggest), .SunkMask(Sunk), .BigLeft(BigLeft),
    .ShotsLeft(ShotsLeft), .GameOver(GameOver), .Won(Won));

  battleship_turn_scorer #(.GRID_MAX(G), .NUM_BIG(NB), .MAX_SHOTS(2)) dut2 (
    .clock(clock), .reset(reset), .X(X), .Y(Y), .Big(Big), .ScoreThis(ScoreThis2),
    .Ready(Ready2), .Done(Done2), .Hit(Hit2), .nearMiss(Near2), .Miss(Miss2),
    .SomethingIsWrong(Wrong2), .HitCount(HitCount2), .numHits(numHits2),
    .BiggestShipHit(Biggest2), .SunkMask(Sunk2), .BigLeft(BigLeft2),
    .ShotsLeft(ShotsLeft2), .GameOver(GameOver2), .Won(Won2));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: grid of ship ids (-1 water) and per-cell hit flags
  int         ship_of  [0:16][0:16];
  bit         mhit     [0:16][0:16];
  int         ship_size[6] = '{5, 4, 3, 3, 2, 2};
  int         ship_bit [6] = '{4, 3, 2, 1, 0, 0};
  int         hits_on  [6];
  int         m_big, m_shots;
  bit         m_over, m_won;
  logic [5:0] m_sunk;
  logic [6:0] seg[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic place(input int id, input int x0, input int y0, input bit horiz);
    for (int k = 0; k < ship_size[id]; k++)
      if (horiz) ship_of[x0 + k][y0] = id;
      else       ship_of[x0][y0 + k] = id;
  endtask

  task automatic model_reset();
    for (int i = 0; i <= 16; i++)
      for (int j = 0; j <= 16; j++) mhit[i][j] = 1'b0;
    for (int s = 0; s < 6; s++) hits_on[s] = 0;
    m_big = NB; m_shots = MS; m_over = 1'b0; m_won = 1'b0; m_sunk = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(Ready), 1);
    chk({tag, "_done"}, 32'(Done), 0);
    chk({tag, "_flags"}, {Hit, nearMiss, Miss, Wrong, GameOver, Won}, 0);
    chk({tag, "_hitcount"}, 32'(HitCount), 0);
    chk({tag, "_numhits"}, 32'(numHits), 32'h40);
    chk({tag, "_biggest"}, 32'(Biggest), 0);
    chk({tag, "_sunk"}, 32'(Sunk), 0);
    chk({tag, "_bigleft"}, 32'(BigLeft), NB);
    chk({tag, "_shotsleft"}, 32'(ShotsLeft), MS);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; ScoreThis = 1'b0; ScoreThis2 = 1'b0;
    @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one request, predict it with the model, and compare latency and outputs
  task automatic do_shot(input int x, input int y, input bit big);
    bit valid, nearf;
    int cnt, best, lat, cyc, seen;
    logic [5:0] prev_sunk;
    if (m_over) begin
      @(negedge clock);
      X = 4'(x); Y = 4'(y); Big = big; ScoreThis = 1'b1;
      @(negedge clock);
      ScoreThis = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        if (Done === 1'b1) seen++;
        @(negedge clock);
      end
      chk("over_no_done", 32'(seen), 0);
      chk("over_ready", 32'(Ready), 0);
      chk("over_gameover", 32'(GameOver), 1);
      return;
    end
    valid = (x >= 1 && x <= G && y >= 1 && y <= G) && !(big && m_big == 0);
    cnt = 0; best = -1; nearf = 1'b0; prev_sunk = m_sunk;
    if (valid) begin
      for (int dx = -1; dx <= 1; dx++)
        for (int dy = -1; dy <= 1; dy++) begin
          int cxm, cym;
          if (!big && (dx != 0 || dy != 0)) continue;
          cxm = x + dx; cym = y + dy;
          if (cxm < 1 || cxm > G || cym < 1 || cym > G) continue;
          if (ship_of[cxm][cym] >= 0) begin
            if (!mhit[cxm][cym]) begin
              mhit[cxm][cym] = 1'b1;
              cnt++;
              hits_on[ship_of[cxm][cym]]++;
              if (ship_bit[ship_of[cxm][cym]] > best) best = ship_bit[ship_of[cxm][cym]];
            end
          end else if (ship_of[cxm+1][cym] >= 0 || ship_of[cxm-1][cym] >= 0 ||
                       ship_of[cxm][cym+1] >= 0 || ship_of[cxm][cym-1] >= 0) begin
            nearf = 1'b1;
          end
        end
      m_shots--;
      if (big) m_big--;
      for (int s = 0; s < 6; s++) m_sunk[5 - s] = (hits_on[s] == ship_size[s]);
      m_won  = (m_sunk == 6'h3F);
      m_over = m_won || (m_shots == 0);
      lat = big ? 10 : 2;
    end else begin
      lat = 1;
    end

    @(negedge clock);
    chk("pre_ready", 32'(Ready), 1);
    X = 4'(x); Y = 4'(y); Big = big; ScoreThis = 1'b1;
    @(negedge clock);
    ScoreThis = 1'b0;
    cyc = 1;
    while (Done !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    chk("wrong", 32'(Wrong), 32'(!valid));
    chk("ready_busy", 32'(Ready), 0);
    if (valid) begin
      chk("hit", 32'(Hit), 32'(cnt > 0));
      chk("nearmiss", 32'(nearMiss), 32'(cnt == 0 && nearf));
      chk("miss", 32'(Miss), 32'(cnt == 0 && !nearf));
      chk("hitcount", 32'(HitCount), 32'(cnt));
      chk("numhits", 32'(numHits), 32'(seg[cnt]));
      chk("biggest", 32'(Biggest), (best < 0) ? 0 : (32'd1 << best));
      chk("sunk", 32'(Sunk), 32'(m_sunk));
      chk("won", 32'(Won), 32'(m_won));
      chk("gameover", 32'(GameOver), 32'(m_over));
    end else begin
      chk("rej_flags", {Hit, nearMiss, Miss}, 0);
      chk("rej_hitcount", 32'(HitCount), 0);
      chk("rej_sunk", 32'(Sunk), 32'(prev_sunk));
    end
    chk("bigleft", 32'(BigLeft), 32'(m_big));
    chk("shotsleft", 32'(ShotsLeft), 32'(m_shots));
  endtask

  initial begin
    int sx[19] = '{2, 3, 4, 5, 6, 1, 2, 3, 4, 2, 3, 4, 2, 2, 2, 7, 8, 9, 10};
    int sy[19] = '{3, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 8, 9, 10, 6, 6, 1, 1};
    int cyc;

    for (int i = 0; i <= 16; i++)
      for (int j = 0; j <= 16; j++) ship_of[i][j] = -1;
    place(0, 2, 3, 1'b1);
    place(1, 1, 2, 1'b1);
    place(2, 2, 1, 1'b1);
    place(3, 2, 8, 1'b0);
    place(4, 7, 6, 1'b1);
    place(5, 9, 1, 1'b1);

    X = '0; Y = '0; Big = 1'b0; ScoreThis = 1'b0; ScoreThis2 = 1'b0; reset = 1'b0;
    do_reset();

    // Single hit, repeat hit, then a Big bomb sinking the cruiser
    do_shot(3, 3, 1'b0);
    do_shot(3, 3, 1'b0);
    do_shot(3, 2, 1'b1);

    // Near miss, plain miss, Big at the corner clipping off-board cells
    do_reset();
    do_shot(1, 1, 1'b0);
    do_shot(10, 10, 1'b0);
    do_shot(1, 1, 1'b1);

    // Rejections: bad X, bad Y, then Big with none left
    do_shot(0, 5, 1'b0);
    do_shot(5, 11, 1'b0);
    do_shot(5, 5, 1'b1);
    do_shot(6, 6, 1'b1);
    do_shot(7, 7, 1'b1);

    // Sink the whole fleet, then confirm requests are ignored
    do_reset();
    for (int i = 0; i < 19; i++) do_shot(sx[i], sy[i], 1'b0);
    chk("won_sunkmask", 32'(Sunk), 32'h3F);
    chk("won_flag", 32'(Won), 1);
    do_shot(5, 5, 1'b0);

    // Shot budget exhaustion on the two-shot instance
    do_reset();
    for (int n = 0; n < 2; n++) begin
      @(negedge clock);
      X = 4'd10; Y = 4'd10; Big = 1'b0; ScoreThis2 = 1'b1;
      @(negedge clock);
      ScoreThis2 = 1'b0;
      repeat (3) @(negedge clock);
    end
    chk("shots2_gameover", 32'(GameOver2), 1);
    chk("shots2_won", 32'(Won2), 0);
    chk("shots2_left", 32'(ShotsLeft2), 0);
    chk("shots2_ready", 32'(Ready2), 0);
    chk("shots2_miss", 32'(Miss2), 1);

    // Reset during the 5th scan cycle of a Big discards the partial shot
    do_reset();
    @(negedge clock);
    X = 4'd3; Y = 4'd2; Big = 1'b1; ScoreThis = 1'b1;
    @(negedge clock);
    ScoreThis = 1'b0;
    cyc = 1;
    repeat (4) begin
      @(negedge clock);
      cyc++;
    end
    chk("midscan_busy", 32'(Ready), 0);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("midscan");
    reset = 1'b0;
    model_reset();
    do_shot(3, 3, 1'b0);
    do_shot(2, 2, 1'b0);

    // Random shots against the model, restarting whenever a game ends
    do_reset();
    for (int n = 0; n < 70; n++) begin
      if (m_over) begin
        do_shot(4, 4, 1'b0);
        do_reset();
      end
      do_shot(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
              ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/battleship_turn_scorer.md
Name: battleship_turn_scorer

Overview:
- Sequential, parametrised scorer for the battleship lab.
- Accepts one shot per handshake: a single cell, or a "Big" 3x3 bomb scanned one cell per clock.
- Keeps a persistent per-cell hit memory, so repeat hits on a cell never score twice.
- Tracks sunk ships, remaining big bombs and remaining shots, and raises game-over/won.
- Sits between the player-input logic and the seven-segment/LED display.

Parameters:
- GRID_MAX, 10: legal coordinates are 1..GRID_MAX for X and Y; must be 3..14.
- NUM_BIG, 3: big bombs available per game; BigLeft width BW = $clog2(NUM_BIG+1).
- MAX_SHOTS, 30: accepted shots per game; ShotsLeft width SW = $clog2(MAX_SHOTS+1).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
X  in  4  shot column
Y  in  4  shot row
Big  in  1  shot is a 3x3 bomb centred on (X,Y)
ScoreThis  in  1  shot request; sampled only when Ready=1
Ready  out  1  block can accept a shot
Done  out  1  one-cycle pulse; result outputs updated this cycle
Hit  out  1  at least one new ship cell hit by last shot
nearMiss  out  1  no new hit, but some scanned non-ship cell is 4-adjacent to a ship cell
Miss  out  1  valid shot with neither Hit nor nearMiss
SomethingIsWrong  out  1  last request rejected
HitCount  out  4  new ship cells hit by last shot, 0..9
numHits  out  7  active-low seven-segment of HitCount (gfedcba)
BiggestShipHit  out  5  one-hot largest ship newly hit: [4] carrier, [3] battleship, [2] cruiser, [1] sub, [0] patrol
SunkMask  out  6  [5] carrier, [4] battleship, [3] cruiser, [2] sub, [1] patrol1, [0] patrol2
BigLeft  out  BW  big bombs remaining
ShotsLeft  out  SW  shots remaining
GameOver  out  1  game finished
Won  out  1  all ships sunk

Behaviour:
- Fixed fleet, 19 cells:
  - carrier Y=3, X=2..6
  - battleship Y=2, X=1..4
  - cruiser Y=1, X=2..4
  - sub X=2, Y=8..10
  - patrol1 Y=6, X=7..8
  - patrol2 Y=1, X=9..10
- Reset values:
  - Ready=1; BigLeft=NUM_BIG; ShotsLeft=MAX_SHOTS; numHits=7'b100_0000.
  - All other outputs and the hit memory are 0.
- FSM states READY, SCAN, REPORT, OVER.
- READY, Ready=1:
  - ScoreThis=1 latches X, Y, Big.
  - Reject if X or Y is outside 1..GRID_MAX, or if Big=1 and BigLeft=0. Then go to REPORT with SomethingIsWrong=1, Hit/nearMiss/Miss=0, HitCount=0, no counters changed.
  - Otherwise clear the per-shot accumulators and go to SCAN.
- SCAN, Ready=0:
  - Single shot: 1 cycle, centre cell only.
  - Big: 9 cycles, dx outer, dy inner, both -1..+1.
  - Offsets use 5-bit arithmetic; cells with coordinate 0 or >GRID_MAX are skipped but still take their cycle.
  - New ship cell: set its hit bit, HitCount+1, update BiggestShipHit by priority carrier>battleship>cruiser>sub>patrol.
  - Already-hit ship cell: no effect.
  - Non-ship cell adjacent to a ship cell: set the near flag.
- REPORT: one cycle.
  - Done=1; register Hit, nearMiss, Miss.
  - For valid shots: ShotsLeft-1; BigLeft-1 if Big.
  - SunkMask bit sets when all of that ship's cells are hit.
  - Next state: OVER if all six ships are sunk (Won=1, GameOver=1) or ShotsLeft reaches 0 (GameOver=1, Won=0); else READY.
- OVER: Ready=0; ScoreThis ignored; only reset exits.
- Latency: accept in cycle 0, Done in cycle 2 (single shot) or cycle 10 (Big); rejected request Done in cycle 1.
- Result outputs hold until the next Done.
- ScoreThis while Ready=0 is ignored, not queued.
- numHits encoding: digits 0-9 standard active-low; any other value 7'h7F.
- Reset asserted in any state, including mid-SCAN: immediate return to reset values; the partial shot is discarded.

Test Plan:
1. Reset; single shot (3,3) -> Done at cycle 2, Hit=1, HitCount=1, numHits=7'b111_1001, BiggestShipHit=5'b10000, ShotsLeft=29; repeat (3,3) -> Hit=0, nearMiss=0, Miss=1, ShotsLeft=28.
2. Big at (3,2) after scenario 1 -> Done 10 cycles after accept, HitCount=8, numHits=7'b000_0000, BiggestShipHit=5'b10000, SunkMask[3]=1, BigLeft=2.
3. Single (1,1) -> nearMiss=1, Hit=0; single (10,10) -> Miss=1; Big at (1,1) skips off-board cells, Hit=1 (cells (1,2),(2,1),(2,2)), HitCount=3.
4. X=0, then Y=11, then Big with BigLeft=0 -> SomethingIsWrong=1 with Done one cycle after request; ShotsLeft and BigLeft unchanged.
5. Hit all 19 ship cells -> Won=1, GameOver=1, Ready=0, SunkMask=6'b111111; later ScoreThis produces no Done. With MAX_SHOTS=2, two misses -> GameOver=1, Won=0.
6. Assert reset during the 5th SCAN cycle of a Big -> all outputs at reset values next cycle; hit memory cleared, so a shot at (3,3) counts as Hit again.
